// File: rtl/seq_detect_param_if.sv
// Signal bundle between a bit-stream source/config master and the pattern detector.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               en;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din;
  logic               din_valid;
  logic               cnt_clr;
  logic               detect;
  logic [CNT_W-1:0]   match_cnt;
  logic [1:0]         state;

  modport master (
    output en, cfg_load, cfg_pattern, cfg_len, cfg_overlap, din, din_valid, cnt_clr,
    input  detect, match_cnt, state
  );

  modport slave (
    input  en, cfg_load, cfg_pattern, cfg_len, cfg_overlap, din, din_valid, cnt_clr,
    output detect, match_cnt, state
  );
endinterface

// File: rtl/seq_detect_param.sv
// Moore serial-pattern detector: programmable pattern/length, overlap mode, saturating match counter.
// Detect is the registered MATCH state, one clk after the completing bit; no backpressure, din_valid qualifies input.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b1010,
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seq_detect_param_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2,
    MATCH = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [MAX_LEN:0]   hist_ext;
  logic [MAX_LEN-1:0] hist_nx;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_nx;
  logic [LEN_W-1:0]   len_clamp;
  logic               hit;

  // Look-ahead of history/fill as if the current bit were accepted.
  always_comb begin
    accept   = bus.en & bus.din_valid & ~bus.cfg_load;
    hist_ext = {hist_q, bus.din};
    hist_nx  = hist_ext[MAX_LEN-1:0];
    fill_nx  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    hit = (fill_nx == len_q) && (((hist_nx ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    len_clamp = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
      len_clamp = LEN_W'(MAX_LEN);
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (!bus.en) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (bus.cfg_load) begin
      state_d = FILL;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      if (accept) begin
        hist_d = hist_nx;
        fill_d = fill_nx;
      end
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: begin
          if (accept) begin
            if (hit)                   state_d = MATCH;
            else if (fill_nx == len_q) state_d = ARMED;
            else                       state_d = FILL;
          end
        end
        ARMED: begin
          if (accept && hit) state_d = MATCH;
        end
        MATCH: begin
          if (accept && hit) state_d = MATCH;
          else               state_d = ovl_q ? ARMED : FILL;
        end
        default: state_d = IDLE;
      endcase
      // Non-overlap mode discards the bits that formed the match.
      if (accept && hit && !ovl_q && state_q != IDLE) begin
        hist_d = '0;
        fill_d = '0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (state_d == MATCH && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= RST_PATTERN;
      len_q   <= LEN_W'(RST_LEN);
      ovl_q   <= RST_OVERLAP;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      if (bus.cfg_load) begin
        pat_q <= bus.cfg_pattern;
        len_q <= len_clamp;
        ovl_q <= bus.cfg_overlap;
      end
    end
  end

  assign bus.detect    = (state_q == MATCH);
  assign bus.match_cnt = cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: two detector instances (8-bit and 2-bit counters) checked against hand-computed values.
module tb_seq_detect_param;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_detect_param_if #(.MAX_LEN(8), .CNT_W(8)) ifa ();
  seq_detect_param_if #(.MAX_LEN(8), .CNT_W(2)) ifb ();

  seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic d, input logic v);
    ifa.din       = d;
    ifa.din_valid = v;
    tick();
  endtask

  task automatic send_b(input logic d, input logic v);
    ifb.din       = d;
    ifb.din_valid = v;
    tick();
  endtask

  task automatic load_a(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic clr);
    ifa.cfg_pattern = pat;
    ifa.cfg_len     = len;
    ifa.cfg_overlap = ovl;
    ifa.cfg_load    = 1'b1;
    ifa.cnt_clr     = clr;
    ifa.din_valid   = 1'b0;
    tick();
    ifa.cfg_load    = 1'b0;
    ifa.cnt_clr     = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic clr);
    ifb.cfg_pattern = pat;
    ifb.cfg_len     = len;
    ifb.cfg_overlap = ovl;
    ifb.cfg_load    = 1'b1;
    ifb.cnt_clr     = clr;
    ifb.din_valid   = 1'b0;
    tick();
    ifb.cfg_load    = 1'b0;
    ifb.cnt_clr     = 1'b0;
  endtask

  initial begin
    logic [5:0] s1;
    logic [5:0] e1;
    logic [7:0] s2;
    logic [7:0] e2;
    logic [3:0] s3;
    logic [1:0] st3 [4];
    logic [1:0] cb  [5];

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {ifa.en, ifa.cfg_load, ifa.cfg_overlap, ifa.din, ifa.din_valid, ifa.cnt_clr} = '0;
    {ifb.en, ifb.cfg_load, ifb.cfg_overlap, ifb.din, ifb.din_valid, ifb.cnt_clr} = '0;
    ifa.cfg_pattern = '0; ifa.cfg_len = '0;
    ifb.cfg_pattern = '0; ifb.cfg_len = '0;

    #8;
    chk("rst_state", 32'(ifa.state), 0);
    chk("rst_detect", 32'(ifa.detect), 0);
    chk("rst_cnt", 32'(ifa.match_cnt), 0);
    #4 rst_n = 1'b1;

    ifa.en = 1'b1;
    ifb.en = 1'b1;
    tick();
    chk("idle_to_fill", 32'(ifa.state), 1);

    // 1: reset config 1010 overlapping, bits 1,0,1,0,1,0
    s1 = 6'b101010;
    e1 = 6'b000101;
    for (int i = 5; i >= 0; i--) begin
      send_a(s1[i], 1'b1);
      chk($sformatf("t1_det_bit%0d", 6 - i), 32'(ifa.detect), 32'(e1[i]));
    end
    chk("t1_cnt", 32'(ifa.match_cnt), 2);
    send_a(1'b0, 1'b0);
    chk("t1_idle_armed", 32'(ifa.state), 2);

    // 2: non-overlap 1010, stream 10101010
    load_a(8'b1010, 4'd4, 1'b0, 1'b1);
    chk("t2_cfg_fill", 32'(ifa.state), 1);
    chk("t2_cnt_clr", 32'(ifa.match_cnt), 0);
    s2 = 8'b10101010;
    e2 = 8'b00010001;
    for (int i = 7; i >= 0; i--) begin
      send_a(s2[i], 1'b1);
      chk($sformatf("t2_det_bit%0d", 8 - i), 32'(ifa.detect), 32'(e2[i]));
    end
    chk("t2_cnt", 32'(ifa.match_cnt), 2);

    // 3: valid gaps between bits
    send_a(1'b0, 1'b0);
    chk("t3_match_to_fill", 32'(ifa.state), 1);
    s3 = 4'b1010;
    st3 = '{2'd1, 2'd1, 2'd1, 2'd3};
    for (int k = 0; k < 4; k++) begin
      send_a(s3[3 - k], 1'b1);
      chk($sformatf("t3_state_bit%0d", k + 1), 32'(ifa.state), 32'(st3[k]));
      chk($sformatf("t3_det_bit%0d", k + 1), 32'(ifa.detect), (k == 3) ? 1 : 0);
      if (k < 3) begin
        for (int g = 0; g < 3; g++) begin
          send_a(1'b1, 1'b0);
          chk($sformatf("t3_gap_det%0d_%0d", k, g), 32'(ifa.detect), 0);
        end
      end
    end
    send_a(1'b0, 1'b0);
    chk("t3_after_det", 32'(ifa.detect), 0);
    chk("t3_cnt", 32'(ifa.match_cnt), 3);

    // 4: len 1 pattern 1 overlapping, five consecutive matches
    load_a(8'b1, 4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_a(1'b1, 1'b1);
      chk($sformatf("t4_det%0d", i), 32'(ifa.detect), 1);
    end
    chk("t4_cnt", 32'(ifa.match_cnt), 5);
    send_a(1'b0, 1'b0);

    // 5: 2-bit counter saturation, clear priority, length clamping
    load_b(8'b1, 4'd1, 1'b1, 1'b0);
    cb = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      send_b(1'b1, 1'b1);
      chk($sformatf("t5_cnt%0d", i), 32'(ifb.match_cnt), 32'(cb[i]));
    end
    ifb.cnt_clr = 1'b1;
    send_b(1'b1, 1'b1);
    ifb.cnt_clr = 1'b0;
    chk("t5_clr_det", 32'(ifb.detect), 1);
    chk("t5_clr_wins", 32'(ifb.match_cnt), 0);
    send_b(1'b1, 1'b1);
    chk("t5_cnt_after_clr", 32'(ifb.match_cnt), 1);
    load_b(8'b1, 4'd0, 1'b1, 1'b0);
    send_b(1'b0, 1'b1);
    chk("t5_len0_nomatch", 32'(ifb.detect), 0);
    send_b(1'b1, 1'b1);
    chk("t5_len0_as1", 32'(ifb.detect), 1);
    load_b(8'hFF, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_b(1'b1, 1'b1);
      chk($sformatf("t5_len15_det%0d", i + 1), 32'(ifb.detect), (i == 7) ? 1 : 0);
    end
    send_b(1'b0, 1'b0);

    // 6: async reset mid-pattern
    load_a(8'b1010, 4'd4, 1'b1, 1'b0);
    send_a(1'b1, 1'b1);
    send_a(1'b0, 1'b1);
    send_a(1'b1, 1'b1);
    chk("t6_pre_state", 32'(ifa.state), 1);
    ifa.din_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(ifa.state), 0);
    chk("t6_rst_detect", 32'(ifa.detect), 0);
    chk("t6_rst_cnt", 32'(ifa.match_cnt), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_rel_fill", 32'(ifa.state), 1);
    send_a(1'b0, 1'b1);
    chk("t6_rst_no_det", 32'(ifa.detect), 0);

    // 6 cont.: en low mid-pattern holds the counter
    load_a(8'b1010, 4'd4, 1'b1, 1'b0);
    send_a(1'b1, 1'b1);
    send_a(1'b0, 1'b1);
    send_a(1'b1, 1'b1);
    send_a(1'b0, 1'b1);
    chk("t6_en_match", 32'(ifa.detect), 1);
    chk("t6_en_cnt1", 32'(ifa.match_cnt), 1);
    load_a(8'b1010, 4'd4, 1'b1, 1'b0);
    send_a(1'b1, 1'b1);
    send_a(1'b0, 1'b1);
    send_a(1'b1, 1'b1);
    ifa.en = 1'b0;
    send_a(1'b0, 1'b0);
    chk("t6_en_idle", 32'(ifa.state), 0);
    chk("t6_en_detect", 32'(ifa.detect), 0);
    chk("t6_en_cnt_held", 32'(ifa.match_cnt), 1);
    ifa.en = 1'b1;
    send_a(1'b0, 1'b0);
    chk("t6_en_refill", 32'(ifa.state), 1);
    send_a(1'b0, 1'b1);
    chk("t6_en_no_det", 32'(ifa.detect), 0);
    chk("t6_en_cnt_final", 32'(ifa.match_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
